// File: rtl/mem_line_ctrl.sv
// Two-port round-robin line-transfer controller: one command per 128-bit line, moved as
// NB bus beats (low beat first) over a shared bidirectional memory data bus.
module mem_line_ctrl #(
    parameter int unsigned MEM_ADDR_SIZE     = 19,
    parameter int unsigned CACHE_OFFSET_SIZE = 4,
    parameter int unsigned BUS_SIZE          = 16,
    parameter int unsigned CACHE_LINE_SIZE   = 16,
    parameter int unsigned RD_LATENCY        = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req0,
    input  logic                                      we0,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] addr0,
    input  logic [CACHE_LINE_SIZE*8-1:0]              wdata0,
    output logic                                      gnt0,
    output logic                                      done0,
    output logic [CACHE_LINE_SIZE*8-1:0]              rdata0,
    input  logic                                      req1,
    input  logic                                      we1,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] addr1,
    input  logic [CACHE_LINE_SIZE*8-1:0]              wdata1,
    output logic                                      gnt1,
    output logic                                      done1,
    output logic [CACHE_LINE_SIZE*8-1:0]              rdata1,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_addr,
    output logic [1:0]                                mem_cmd,
    inout  wire  [BUS_SIZE-1:0]                       mem_data,
    output logic                                      busy
);
    localparam int unsigned LA        = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int unsigned LW        = CACHE_LINE_SIZE * 8;
    localparam int unsigned NB        = LW / BUS_SIZE;
    localparam int unsigned CW        = $clog2(NB);
    localparam int unsigned WW        = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;
    localparam int unsigned WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    localparam logic [1:0] CMD_NOP   = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_RD_WAIT, S_RD_BEAT, S_WR_BEAT, S_FIN
    } state_e;

    state_e          state_q, state_d;
    logic            pref_q, pref_d, owner_q, owner_d, we_q, we_d;
    logic [LA-1:0]   addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [LW-1:0]   wdata_q, wdata_d, buf_q, buf_d, line_c;
    logic [LW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [CW-1:0]   cnt_q, cnt_d, rd_idx_q, rd_idx_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
    logic [1:0]      mem_cmd_q, mem_cmd_d;
    logic            oe_q, oe_d, rd_en_q, rd_en_d, busy_q, busy_d, win_c;
    logic [BUS_SIZE-1:0] wbeat_q, wbeat_d;

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_addr = mem_addr_q;
    assign mem_cmd  = mem_cmd_q;
    assign busy     = busy_q;
    assign mem_data = oe_q ? wbeat_q : {BUS_SIZE{1'bz}};

    // Bus outputs are registered one cycle behind the state, so read sampling
    // follows a delayed strobe (rd_en_q/rd_idx_q) aligned with the bus beat.
    always_comb begin
        state_d    = state_q;
        pref_d     = pref_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        mem_cmd_d  = CMD_NOP;
        oe_d       = 1'b0;
        wbeat_d    = wbeat_q;
        rd_en_d    = 1'b0;
        rd_idx_d   = cnt_q;
        busy_d     = (state_q != S_IDLE);
        win_c      = (req0 && req1) ? pref_q : req1;

        line_c = buf_q;
        if (rd_en_q) begin
            line_c[BUS_SIZE*rd_idx_q +: BUS_SIZE] = mem_data;
        end
        buf_d = line_c;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = win_c;
                    pref_d  = ~win_c;
                    gnt0_d  = ~win_c;
                    gnt1_d  = win_c;
                    we_d    = win_c ? we1 : we0;
                    addr_d  = win_c ? addr1 : addr0;
                    wdata_d = win_c ? wdata1 : wdata0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                mem_cmd_d  = we_q ? CMD_WRITE : CMD_READ;
                mem_addr_d = addr_q;
                cnt_d      = '0;
                wait_d     = '0;
                if (we_q)                state_d = S_WR_BEAT;
                else if (RD_LATENCY > 1) state_d = S_RD_WAIT;
                else                     state_d = S_RD_BEAT;
            end
            S_RD_WAIT: begin
                if (wait_q == WW'(WAIT_LAST)) state_d = S_RD_BEAT;
                else                          wait_d  = wait_q + WW'(1);
            end
            S_RD_BEAT: begin
                rd_en_d = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NB - 1)) state_d = S_FIN;
            end
            S_WR_BEAT: begin
                oe_d    = 1'b1;
                wbeat_d = wdata_q[BUS_SIZE*cnt_q +: BUS_SIZE];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NB - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                done0_d = ~owner_q;
                done1_d = owner_q;
                if (!we_q) begin
                    if (owner_q) rdata1_d = line_c;
                    else         rdata0_d = line_c;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pref_q     <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            buf_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            wait_q     <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            mem_cmd_q  <= CMD_NOP;
            oe_q       <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            wbeat_q    <= '0;
        end else begin
            state_q    <= state_d;
            pref_q     <= pref_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            buf_q      <= buf_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            cnt_q      <= cnt_d;
            rd_idx_q   <= rd_idx_d;
            wait_q     <= wait_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            mem_cmd_q  <= mem_cmd_d;
            oe_q       <= oe_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            wbeat_q    <= wbeat_d;
        end
    end
endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl: per-port expected queues, a cycle-level monitor and
// behavioural memory models for the default instance and an RD_LATENCY=3 instance.
module tb_mem_line_ctrl;
    typedef struct packed {
        logic         we;
        logic [14:0]  addr;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic req0, req1, we0, we1, gnt0, gnt1, done0, done1, busy;
    logic [14:0] addr0, addr1, mem_addr;
    logic [127:0] wdata0, wdata1, rdata0, rdata1;
    logic [1:0] mem_cmd;
    wire  [15:0] mem_data;
    logic mem_oe;
    logic [15:0] mem_drv;
    assign mem_data = mem_oe ? mem_drv : 16'bz;
    pullup (mem_data);

    logic req0_b, req1_b, we0_b, we1_b, gnt0_b, gnt1_b, done0_b, done1_b, busy_b;
    logic [14:0] addr0_b, addr1_b, mem_addr_b;
    logic [127:0] wdata0_b, wdata1_b, rdata0_b, rdata1_b;
    logic [1:0] mem_cmd_b;
    wire  [15:0] mem_data_b;
    logic mem_oe_b;
    logic [15:0] mem_drv_b;
    assign mem_data_b = mem_oe_b ? mem_drv_b : 16'bz;
    pullup (mem_data_b);

    mem_line_ctrl u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_data(mem_data), .busy(busy)
    );

    mem_line_ctrl #(.RD_LATENCY(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .gnt0(gnt0_b), .done0(done0_b), .rdata0(rdata0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .gnt1(gnt1_b), .done1(done1_b), .rdata1(rdata1_b),
        .mem_addr(mem_addr_b), .mem_cmd(mem_cmd_b), .mem_data(mem_data_b), .busy(busy_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int g_last = -1000;
    int issued = 0;
    int completed = 0;
    exp_t q0[$];
    exp_t q1[$];
    int gnt_log[$];
    logic [127:0] ref_mem [logic [14:0]];
    logic [127:0] bus_mem [logic [14:0]];
    logic [127:0] exp_rdata0 = '0;
    logic [127:0] exp_rdata1 = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Power-on content of every line: beat i = 0x1000 + i + 16*(addr-5).
    function automatic logic [127:0] default_line(input logic [14:0] a);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) l[16*i +: 16] = 16'(32'h1000 + 32'(i) + 32'(a) * 16 - 80);
        return l;
    endfunction

    function automatic logic [127:0] ref_line(input logic [14:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : default_line(a);
    endfunction

    function automatic logic [127:0] bus_line(input logic [14:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : default_line(a);
    endfunction

    // Memory on the default bus: read beats start one cycle after the command cycle.
    initial begin : mem_model
        logic [14:0] a;
        logic [127:0] l;
        mem_oe = 1'b0;
        mem_drv = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_cmd == 2'd3) begin
                a = mem_addr;
                l = '0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    l[16*i +: 16] = mem_data;
                end
                bus_mem[a] = l;
            end else if (!reset && mem_cmd == 2'd2) begin
                l = bus_line(mem_addr);
                @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    #1 mem_drv = l[16*i +: 16];
                    mem_oe = 1'b1;
                    @(posedge clk);
                end
                #1 mem_oe = 1'b0;
            end
        end
    end

    // Memory for the RD_LATENCY=3 instance (reads only).
    initial begin : mem_model_b
        logic [127:0] l;
        mem_oe_b = 1'b0;
        mem_drv_b = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_cmd_b == 2'd2) begin
                l = default_line(mem_addr_b);
                repeat (3) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    #1 mem_drv_b = l[16*i +: 16];
                    mem_oe_b = 1'b1;
                    @(posedge clk);
                end
                #1 mem_oe_b = 1'b0;
            end
        end
    end

    // Monitor: grant at g, command at g+1, busy g+1..g+10, done at g+10.
    initial begin : monitor
        exp_t cur;
        int own;
        cur = '0;
        own = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                g_last = -1000;
                exp_rdata0 = '0;
                exp_rdata1 = '0;
                continue;
            end
            if (gnt0 || gnt1) begin
                chk("gnt_onehot", 128'(gnt0 && gnt1), 128'(0));
                if (g_last > -1000) chk("gnt_gap", 128'((cyc - g_last) >= 11), 128'(1));
                own = gnt1 ? 1 : 0;
                g_last = cyc;
                gnt_log.push_back(own);
                if (own == 0 && q0.size() > 0)      cur = q0.pop_front();
                else if (own == 1 && q1.size() > 0) cur = q1.pop_front();
                else chk("gnt_unexpected", 128'(1), 128'(0));
            end
            chk("busy", 128'(busy), 128'(cyc > g_last && cyc <= g_last + 10));
            chk("mem_cmd", 128'(mem_cmd), 128'((cyc == g_last + 1) ? (cur.we ? 3 : 2) : 0));
            if (cyc > g_last && cyc <= g_last + 10) chk("mem_addr", 128'(mem_addr), 128'(cur.addr));
            if (cyc == g_last + 1 || cyc == g_last + 10) chk("bus_released", 128'(mem_data), 128'(16'hFFFF));
            chk("done0", 128'(done0), 128'(cyc == g_last + 10 && own == 0));
            chk("done1", 128'(done1), 128'(cyc == g_last + 10 && own == 1));
            if (cyc == g_last + 10) begin
                completed++;
                if (cur.we)        chk("wr_line", bus_line(cur.addr), cur.data);
                else if (own == 0) exp_rdata0 = cur.data;
                else               exp_rdata1 = cur.data;
            end
            chk("rdata0", rdata0, exp_rdata0);
            chk("rdata1", rdata1, exp_rdata1);
        end
    end

    task automatic do_req(input int p, input logic we, input logic [14:0] a,
                          input logic [127:0] d, input bit keep);
        exp_t e;
        bit got;
        e.we = we;
        e.addr = a;
        e.data = we ? d : ref_line(a);
        if (we) ref_mem[a] = d;
        issued++;
        if (p == 0) begin q0.push_back(e); we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
        else        begin q1.push_back(e); we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? gnt0 : gnt1;
        end
        chk("gnt_wait", 128'(got), 128'(1));
        if (!keep) begin
            if (p == 0) req0 = 1'b0;
            else        req1 = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400; k++) begin
            if (issued == completed && cyc > g_last + 10 && !busy) break;
            @(negedge clk);
        end
        chk("drain", 128'(k < 400), 128'(1));
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] d;
        int k;
        int exp_order [4] = '{0, 1, 0, 1};
        reset = 1'b1;
        {req0, req1, we0, we1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        {req0_b, req1_b, we0_b, we1_b} = '0;
        addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 128'({gnt0, gnt1}), 128'(0));
        chk("rst_done", 128'({done0, done1}), 128'(0));
        chk("rst_rdata0", rdata0, 128'(0));
        chk("rst_rdata1", rdata1, 128'(0));
        chk("rst_cmd", 128'(mem_cmd), 128'(0));
        chk("rst_addr", 128'(mem_addr), 128'(0));
        chk("rst_bus", 128'(mem_data), 128'(16'hFFFF));
        chk("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single read on port 0.
        do_req(0, 1'b0, 15'h0005, '0, 1'b0);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done0) break;
        end
        chk("t1_done_latency", 128'(k), 128'(10));
        chk("t1_rdata0", rdata0, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
        drain();

        // Single write on port 1 at the top line address.
        d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        do_req(1, 1'b1, 15'h7FFF, d, 1'b0);
        drain();
        chk("t2_line", bus_line(15'h7FFF), d);

        // Both requests held from reset: alternating grants starting with port 0.
        reset = 1'b1;
        gnt_log.delete();
        fork
            begin do_req(0, 1'b0, 15'h0100, '0, 1'b1); do_req(0, 1'b1, 15'h0102, rnd_line(), 1'b0); end
            begin do_req(1, 1'b1, 15'h0101, rnd_line(), 1'b1); do_req(1, 1'b0, 15'h0101, '0, 1'b0); end
            begin repeat (2) @(negedge clk); reset = 1'b0; end
        join
        drain();
        chk("t3_grants", 128'(gnt_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("t3_order", 128'(gnt_log[i]), 128'(exp_order[i]));

        // Port 0 inputs change while its read is in flight.
        do_req(0, 1'b0, 15'h0040, '0, 1'b0);
        repeat (4) @(negedge clk);
        addr0 = 15'h5555;
        we0 = 1'b1;
        wdata0 = rnd_line();
        drain();
        chk("t6_rdata0", rdata0, default_line(15'h0040));
        chk("t6_rdata1", rdata1, exp_rdata1);

        // Random traffic; port 0 uses even lines, port 1 odd lines.
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_req(0, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 7) * 2), rnd_line(), 1'b0);
                end
            end
            begin
                for (int n = 0; n < 25; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_req(1, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 7) * 2 + 1), rnd_line(), 1'b0);
                end
            end
        join
        drain();

        // Reset during write beat 4, then a fresh read.
        d = rnd_line();
        do_req(1, 1'b1, 15'h1234, d, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t4_beat4", 128'(mem_data), 128'(d[64 +: 16]));
        reset = 1'b1;
        q1.delete();
        issued = completed;
        @(negedge clk);
        chk("t4_cmd", 128'(mem_cmd), 128'(0));
        chk("t4_bus", 128'(mem_data), 128'(16'hFFFF));
        chk("t4_busy", 128'(busy), 128'(0));
        chk("t4_done", 128'({done0, done1}), 128'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_req(0, 1'b0, 15'h0005, '0, 1'b0);
        drain();
        chk("t4_fresh_read", rdata0, ref_line(15'h0005));

        // RD_LATENCY=3 instance.
        req0_b = 1'b1;
        addr0_b = 15'h0010;
        we0_b = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt0_b) break;
        end
        chk("t5_gnt", 128'(gnt0_b), 128'(1));
        req0_b = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("t5_cmd", 128'(mem_cmd_b), 128'(2));
            if (done0_b) break;
        end
        chk("t5_done_latency", 128'(k), 128'(12));
        chk("t5_rdata0", rdata0_b, default_line(15'h0010));
        chk("t5_rdata1", rdata1_b, 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
